list_reader: RTL and testbench
==============================

LIST_READER -- requirements
Module: list_reader

Interface
REQ-001 MAX_CARDS, 52, maximum number of nodes walked before the walk is declared runaway (range 1..63).
REQ-002 clock  input  1  sole clock; all state changes on its rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 enable  input  1  start request, sampled only in IDLE.
REQ-005 head_addr  input  10  address of the first node; 0 means empty list.
REQ-006 out_value  output  6  card value of the current node.
REQ-007 out_valid  output  1  out_value is valid and offered to the consumer.
REQ-008 out_ready  input  1  consumer accepts out_value this cycle.
REQ-009 card_count  output  6  number of cards accepted by the consumer in the current or last walk.
REQ-010 finished  output  1  high when no walk is in progress, and after the last walk completed.
REQ-011 error  output  1  last walk ended on an unallocated node or a runaway.
REQ-012 ram_address  output  10  RAM address.
REQ-013 ram_clock  output  1  equals clock.
REQ-014 ram_data  output  32  constant 0.
REQ-015 ram_wren  output  1  constant 0 (read-only block).
REQ-016 ram_q  input  32  RAM read data.

Function
REQ-017 Node word format: bit 31 = allocated flag; bits 15:10 = card value; bits 9:0 = next-node address; next = 0 terminates the list.
REQ-018 RAM read latency: ram_q reflects ram_address two rising edges after ram_address changes.
REQ-019 FSM states: IDLE, ISSUE, WAIT, CAPTURE, EMIT; one state per cycle except EMIT, which holds.
REQ-020 IDLE: on enable=1, latch head_addr into cur_addr, clear card_count, error and finished; go to ISSUE, or remain in IDLE with finished=1 when head_addr=0.
REQ-021 ISSUE: drive ram_address=cur_addr; go to WAIT.
REQ-022 WAIT: hold ram_address; go to CAPTURE.
REQ-023 CAPTURE: latch ram_q; if bit 31=0, set error=1 and finished=1 and go to IDLE; otherwise load out_value from bits 15:10 and go to EMIT.
REQ-024 EMIT: out_valid=1; out_value and out_valid stay stable until out_valid and out_ready are both 1 on the same edge.
REQ-025 On handshake: card_count increments and out_valid drops the next cycle; if next=0, set finished=1 and go to IDLE.
REQ-026 On handshake with next!=0: if card_count+1 = MAX_CARDS, set error=1 and finished=1 and go to IDLE; otherwise load cur_addr=next and go to ISSUE.
REQ-027 enable asserted outside IDLE is ignored; an enable still high on return to IDLE starts a new walk.
REQ-028 card_count never wraps; it is bounded by MAX_CARDS.
REQ-029 out_valid is 0 in every state except EMIT.
REQ-030 Minimum per-card cost is 4 cycles (ISSUE, WAIT, CAPTURE, EMIT with out_ready=1).

Reset
REQ-031 On resetn=0, immediately and regardless of state: state=IDLE, out_valid=0, out_value=0, card_count=0, error=0, finished=1, ram_address=0, ram_wren=0.
REQ-032 On reset mid-walk, the walk is abandoned with no further handshake; the next walk starts only on a new enable.

Verification
REQ-033 RAM 32={1,val 5,next 64}, 64={1,val 17,next 0}; head=32, enable pulse, out_ready=1 -> values 5 then 17, card_count=2, finished=1, error=0; first out_valid 4 cycles after enable.
REQ-034 head_addr=0, enable -> stays IDLE, finished=1, card_count=0, out_valid never asserted.
REQ-035 Same list as REQ-033, out_ready held 0 for 10 cycles -> out_valid=1 with out_value=5 stable throughout; the walk resumes when out_ready rises.
REQ-036 Node 32 with bit 31=0, head=32 -> error=1, finished=1, card_count=0, no out_valid.
REQ-037 Self loop 32={1,val 3,next 32}, MAX_CARDS=52 -> exactly 52 handshakes, then error=1, finished=1.
REQ-038 resetn pulsed low during the second EMIT of REQ-033 -> all outputs return to reset values asynchronously; ram_wren remains 0 at all times.

Source files
------------

// File: rtl/list_reader.sv
// Walks a linked list of card nodes held in a read-only RAM and offers each
// card value to a consumer over a valid/ready port.
module list_reader #(
    parameter int MAX_CARDS = 52
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        enable,
    input  logic [9:0]  head_addr,
    output logic [5:0]  out_value,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [5:0]  card_count,
    output logic        finished,
    output logic        error,
    output logic [9:0]  ram_address,
    output logic        ram_clock,
    output logic [31:0] ram_data,
    output logic        ram_wren,
    input  logic [31:0] ram_q,
    output logic [2:0]  fsm_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_CAPTURE = 3'd3,
        S_EMIT    = 3'd4
    } state_t;

    localparam logic [5:0] MAX_C = 6'(MAX_CARDS);

    state_t     state, state_d;
    logic [9:0] cur_addr, cur_d;
    logic [9:0] next_addr, next_d;
    logic [5:0] value_r, value_d;
    logic [5:0] count_r, count_d;
    logic       error_r, error_d;
    logic       finished_r, finished_d;

    // Handshake: a card transfers on a rising edge where out_valid and
    // out_ready are both 1; out_value is held stable until that edge.
    always_comb begin
        state_d    = state;
        cur_d      = cur_addr;
        next_d     = next_addr;
        value_d    = value_r;
        count_d    = count_r;
        error_d    = error_r;
        finished_d = finished_r;
        case (state)
            S_IDLE: begin
                if (enable) begin
                    count_d = 6'd0;
                    error_d = 1'b0;
                    if (head_addr == 10'd0) begin
                        finished_d = 1'b1;
                    end else begin
                        finished_d = 1'b0;
                        cur_d      = head_addr;
                        state_d    = S_ISSUE;
                    end
                end
            end
            S_ISSUE:   state_d = S_WAIT;
            S_WAIT:    state_d = S_CAPTURE;
            S_CAPTURE: begin
                if (!ram_q[31]) begin
                    error_d    = 1'b1;
                    finished_d = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    value_d = ram_q[15:10];
                    next_d  = ram_q[9:0];
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    count_d = count_r + 6'd1;
                    if (next_addr == 10'd0) begin
                        finished_d = 1'b1;
                        state_d    = S_IDLE;
                    end else if (count_r + 6'd1 == MAX_C) begin
                        // Runaway guard: a cyclic list stops here.
                        error_d    = 1'b1;
                        finished_d = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        cur_d   = next_addr;
                        state_d = S_ISSUE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            cur_addr   <= 10'd0;
            next_addr  <= 10'd0;
            value_r    <= 6'd0;
            count_r    <= 6'd0;
            error_r    <= 1'b0;
            finished_r <= 1'b1;
        end else begin
            state      <= state_d;
            cur_addr   <= cur_d;
            next_addr  <= next_d;
            value_r    <= value_d;
            count_r    <= count_d;
            error_r    <= error_d;
            finished_r <= finished_d;
        end
    end

    // cur_addr is loaded on the edge entering ISSUE, so the RAM sees the
    // address two edges before CAPTURE samples ram_q.
    assign ram_address = cur_addr;
    assign ram_clock   = clock;
    assign ram_data    = 32'd0;
    assign ram_wren    = 1'b0;
    assign out_value   = value_r;
    assign out_valid   = (state == S_EMIT);
    assign card_count  = count_r;
    assign error       = error_r;
    assign finished    = finished_r;
    assign fsm_state   = state;

endmodule

// File: tb/tb_list_reader.sv
// Bench for list_reader: RAM model with two-edge read latency, list-walk
// reference model feeding an expected-card queue, and a handshake monitor.
module tb_list_reader;

    localparam int MAX_CARDS = 52;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        enable = 1'b0;
    logic [9:0]  head_addr = 10'd0;
    logic [5:0]  out_value;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  card_count;
    logic        finished;
    logic        error;
    logic [9:0]  ram_address;
    logic        ram_clock;
    logic [31:0] ram_data;
    logic        ram_wren;
    logic [31:0] ram_q = 32'd0;
    logic [2:0]  fsm_state;

    list_reader #(.MAX_CARDS(MAX_CARDS)) dut (
        .clock(clock), .resetn(resetn), .enable(enable), .head_addr(head_addr),
        .out_value(out_value), .out_valid(out_valid), .out_ready(out_ready),
        .card_count(card_count), .finished(finished), .error(error),
        .ram_address(ram_address), .ram_clock(ram_clock), .ram_data(ram_data),
        .ram_wren(ram_wren), .ram_q(ram_q), .fsm_state(fsm_state)
    );

    always #5 clock = ~clock;

    // RAM: two-stage read pipeline
    logic [31:0] mem [1024];
    logic [31:0] ram_r1 = 32'd0;
    always @(posedge clock) begin
        ram_r1 <= mem[ram_address];
        ram_q  <= ram_r1;
    end

    // Consumer ready: 0 = always ready, 1 = random, 2 = manual
    int   ready_mode = 0;
    logic manual_ready = 1'b0;
    logic rnd_ready = 1'b1;
    always @(posedge clock) begin
        #1;
        rnd_ready = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    assign out_ready = (ready_mode == 2) ? manual_ready : rnd_ready;

    int vectors = 0;
    int miscompares = 0;
    logic [5:0] exp_q[$];
    int exp_count;
    logic exp_err;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops an expected card on each handshake, checks stall stability
    logic       stall_prev = 1'b0;
    logic [5:0] held_value = 6'd0;
    always @(negedge clock) begin
        chk("ram_wren", int'(ram_wren), 0);
        if (out_valid && stall_prev)
            chk("stall_stable", int'(out_value), int'(held_value));
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_card", 1, 0);
            end else begin
                chk("card_value", int'(out_value), int'(exp_q.pop_front()));
            end
        end
        stall_prev = out_valid && !out_ready;
        held_value = out_value;
    end

    // Reference: walk the list in the RAM image, pushing every card offered.
    task automatic model_walk(input logic [9:0] head);
        int a = int'(head);
        int n = 0;
        exp_err = 1'b0;
        while (a != 0) begin
            if (!mem[a][31]) begin
                exp_err = 1'b1;
                break;
            end
            exp_q.push_back(mem[a][15:10]);
            n++;
            if (mem[a][9:0] == 10'd0) break;
            if (n == MAX_CARDS) begin
                exp_err = 1'b1;
                break;
            end
            a = int'(mem[a][9:0]);
        end
        exp_count = n;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    endtask

    function automatic logic [31:0] node(input bit alloc, input int val, input int nxt);
        return {alloc, 15'($urandom), 6'(val), 10'(nxt)};
    endfunction

    task automatic pulse_enable(input logic [9:0] head);
        model_walk(head);
        head_addr = head;
        @(posedge clock); #1;
        enable = 1'b1;
        @(posedge clock); #1;
        enable = 1'b0;
    endtask

    // Waits until the walk ends; optionally checks first out_valid latency.
    task automatic finish_walk(input bit chk_lat, input string tag);
        int  lat = 1;
        bit  seen = 0;
        bit  done = 0;
        for (int c = 0; c < 5000; c++) begin
            if (!seen && out_valid) begin
                seen = 1;
                if (chk_lat) chk({tag, "_first_valid_latency"}, lat, 4);
            end
            if (finished && !out_valid) begin
                done = 1;
                break;
            end
            @(posedge clock); #1;
            lat++;
        end
        if (!done) chk({tag, "_walk_timeout"}, 1, 0);
        chk({tag, "_card_count"}, int'(card_count), exp_count);
        chk({tag, "_error"}, int'(error), int'(exp_err));
        chk({tag, "_finished"}, int'(finished), 1);
        chk({tag, "_cards_left"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic wait_valid(input string tag);
        for (int c = 0; c < 200; c++) begin
            if (out_valid) return;
            @(posedge clock); #1;
        end
        chk({tag, "_valid_timeout"}, 1, 0);
    endtask

    task automatic build_random_list(output logic [9:0] head);
        int len = $urandom_range(1, 6);
        int kind = $urandom_range(0, 9);
        int addr [6];
        bit used [1024];
        for (int i = 0; i < 1024; i++) used[i] = 0;
        clear_mem();
        for (int i = 0; i < len; i++) begin
            do addr[i] = $urandom_range(1, 1023); while (used[addr[i]]);
            used[addr[i]] = 1;
        end
        for (int i = 0; i < len; i++)
            mem[addr[i]] = node(1'b1, $urandom_range(0, 63), (i < len - 1) ? addr[i + 1] : 0);
        if (kind == 0) mem[addr[$urandom_range(0, len - 1)]][31] = 1'b0;
        if (kind == 1) mem[addr[len - 1]][9:0] = 10'(addr[0]);
        head = 10'(addr[0]);
    endtask

    initial begin
        logic [9:0] rh;
        clear_mem();
        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_value", int'(out_value), 0);
        chk("rst_card_count", int'(card_count), 0);
        chk("rst_error", int'(error), 0);
        chk("rst_finished", int'(finished), 1);
        chk("rst_ram_address", int'(ram_address), 0);
        chk("rst_ram_data", int'(ram_data), 0);
        resetn = 1'b1;
        @(posedge clock); #1;

        // Two-node list, always ready
        mem[32] = node(1'b1, 5, 64);
        mem[64] = node(1'b1, 17, 0);
        ready_mode = 0;
        pulse_enable(10'd32);
        finish_walk(1'b1, "two_node");

        // Empty list
        pulse_enable(10'd0);
        finish_walk(1'b0, "empty");

        // Consumer stalls 10 cycles on the first card
        ready_mode = 2;
        manual_ready = 1'b0;
        pulse_enable(10'd32);
        wait_valid("stall");
        for (int i = 0; i < 10; i++) begin
            chk("stall_valid", int'(out_valid), 1);
            chk("stall_value", int'(out_value), 5);
            @(posedge clock); #1;
        end
        manual_ready = 1'b1;
        finish_walk(1'b0, "stall");

        // Unallocated head node
        mem[32] = node(1'b0, 9, 64);
        ready_mode = 0;
        pulse_enable(10'd32);
        finish_walk(1'b0, "unalloc");

        // Empty list after an error clears the error flag
        pulse_enable(10'd0);
        finish_walk(1'b0, "empty_after_err");

        // Self loop runs into the card limit
        mem[32] = node(1'b1, 3, 32);
        pulse_enable(10'd32);
        finish_walk(1'b1, "self_loop");

        // Reset during the second EMIT
        mem[32] = node(1'b1, 5, 64);
        ready_mode = 2;
        manual_ready = 1'b0;
        pulse_enable(10'd32);
        wait_valid("rst_mid");
        manual_ready = 1'b1;
        @(posedge clock); #1;
        manual_ready = 1'b0;
        wait_valid("rst_mid2");
        chk("rst_mid_second_value", int'(out_value), 17);
        #2;
        resetn = 1'b0;
        #1;
        exp_q.delete();
        chk("rst_mid_out_valid", int'(out_valid), 0);
        chk("rst_mid_out_value", int'(out_value), 0);
        chk("rst_mid_card_count", int'(card_count), 0);
        chk("rst_mid_finished", int'(finished), 1);
        chk("rst_mid_error", int'(error), 0);
        chk("rst_mid_ram_address", int'(ram_address), 0);
        @(posedge clock); #1;
        resetn = 1'b1;
        manual_ready = 1'b1;
        repeat (8) @(posedge clock);
        #1;
        chk("rst_mid_idle_finished", int'(finished), 1);
        chk("rst_mid_idle_count", int'(card_count), 0);
        chk("rst_mid_idle_valid", int'(out_valid), 0);

        // Random lists with a random consumer
        ready_mode = 1;
        for (int t = 0; t < 25; t++) begin
            build_random_list(rh);
            pulse_enable(rh);
            finish_walk(1'b1, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
